// File: rtl/vga_gpu_pkg.sv
// Shared timing defaults, pixel type and bar colour table for the vga_gpu video source.
// Consumers: vga_timing and vga_gpu (optional scrolling enabled by VGA_GPU_SCROLL_EN).
package vga_gpu_pkg;

   localparam int DEF_H_ACTIVE = 200;
   localparam int DEF_H_FP     = 10;
   localparam int DEF_H_SYNC   = 32;
   localparam int DEF_H_BP     = 22;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 23;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam bit DEF_SYNC_POL = 1'b1;
   localparam int N_BARS       = 8;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   // White, yellow, cyan, green, magenta, red, blue, black
   localparam rgb_t BAR_COLORS [N_BARS] = '{
      '{4'hF, 4'hF, 4'hF},
      '{4'hF, 4'hF, 4'h0},
      '{4'h0, 4'hF, 4'hF},
      '{4'h0, 4'hF, 4'h0},
      '{4'hF, 4'h0, 4'hF},
      '{4'hF, 4'h0, 4'h0},
      '{4'h0, 4'h0, 4'hF},
      '{4'h0, 4'h0, 4'h0}
   };

   function automatic logic sync_level(input logic in_pulse, input bit pol);
      return in_pulse ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with active-area and sync-window decode.
// Counters pause for one edge after reset so that position (0,0) is presented first.
module vga_timing
   import vga_gpu_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int H_CNT_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int V_CNT_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic               clk,
   input  logic               aresetn,
   output logic [H_CNT_W-1:0] h_cnt,
   output logic [V_CNT_W-1:0] v_cnt,
   output logic               active,
   output logic               hs,
   output logic               vs
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
   localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
   localparam logic [H_CNT_W-1:0] H_SYNC_LO  = H_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_CNT_W-1:0] H_SYNC_HI  = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
   localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
   localparam logic [V_CNT_W-1:0] V_SYNC_LO  = V_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [V_CNT_W-1:0] V_SYNC_HI  = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic hold_q;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
   // blocking here would let v_cnt see the already-updated h_cnt.
   always_ff @(posedge clk) begin
      if (aresetn) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         hold_q <= 1'b1;
      end else begin
         hold_q <= 1'b0;
         if (!hold_q) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

   assign active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
   assign hs     = (h_cnt >= H_SYNC_LO) && (h_cnt <= H_SYNC_HI);
   assign vs     = (v_cnt >= V_SYNC_LO) && (v_cnt <= V_SYNC_HI);

endmodule

// File: rtl/vga_gpu.sv
// 8-colour vertical bar test pattern source with registered RGB/sync outputs.
// Define VGA_GPU_SCROLL_EN to scroll the pattern left by one column per frame.
module vga_gpu
   import vga_gpu_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = DEF_SYNC_POL
) (
   input  logic       clk,
   input  logic       aresetn,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       h_sync,
   output logic       v_sync
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_CNT_W = $clog2(H_TOTAL);
   localparam int V_CNT_W = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / N_BARS;

   logic [H_CNT_W-1:0] h_cnt;
   logic [V_CNT_W-1:0] v_cnt;
   logic               active;
   logic               hs;
   logic               vs;
   logic [2:0]         bar_idx;
   int                 col;
   rgb_t               pix_q;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .H_CNT_W  (H_CNT_W),
      .V_CNT_W  (V_CNT_W)
   ) u_timing (
      .clk     (clk),
      .aresetn (aresetn),
      .h_cnt   (h_cnt),
      .v_cnt   (v_cnt),
      .active  (active),
      .hs      (hs),
      .vs      (vs)
   );

`ifdef VGA_GPU_SCROLL_EN
   localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
   localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);

   logic [7:0] frame_cnt;

   // Advances on the same edge that the raster wraps back to (0,0)
   always_ff @(posedge clk) begin
      if (aresetn) begin
         frame_cnt <= '0;
      end else if ((h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // NOTE: every always_comb output is assigned on every path; a missed branch
   // would infer a latch.
   always_comb begin
      col     = (int'(h_cnt) + int'(frame_cnt)) % H_ACTIVE;
      bar_idx = 3'(col / BAR_W);
   end
`else
   logic v_cnt_unused;
   assign v_cnt_unused = ^v_cnt;

   always_comb begin
      col     = int'(h_cnt);
      bar_idx = 3'(col / BAR_W);
   end
`endif

   // Single output stage keeps RGB and both syncs aligned to the same raster position
   always_ff @(posedge clk) begin
      if (aresetn) begin
         pix_q  <= '0;
         h_sync <= ~SYNC_POL;
         v_sync <= ~SYNC_POL;
      end else begin
         pix_q  <= active ? BAR_COLORS[bar_idx] : '0;
         h_sync <= sync_level(hs, SYNC_POL);
         v_sync <= sync_level(vs, SYNC_POL);
      end
   end

   assign red   = pix_q.r;
   assign green = pix_q.g;
   assign blue  = pix_q.b;

endmodule

// File: tb/tb_vga_gpu.sv
// Self-checking bench for vga_gpu; vertical active area is shortened so several
// full frames fit in a short run, all expectations derive from the constants below.
module tb_vga_gpu;

   localparam int H_ACT   = 200;
   localparam int H_FP    = 10;
   localparam int H_SYNC  = 32;
   localparam int H_BP    = 22;
   localparam int H_TOT   = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_ACT   = 8;
   localparam int V_FP    = 1;
   localparam int V_SYNC  = 4;
   localparam int V_BP    = 23;
   localparam int V_TOT   = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int FRAME   = H_TOT * V_TOT;
   localparam int H_RISE_K = H_ACT + H_FP + 1;
`ifdef VGA_GPU_SCROLL_EN
   localparam int LEAD_F1 = 24;
`else
   localparam int LEAD_F1 = 25;
`endif

   logic       clk = 1'b0;
   logic       aresetn = 1'b1;
   logic [3:0] red, green, blue;
   logic       h_sync, v_sync;

   int          k;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [13:0] exp_q [$];
   logic [11:0] rgb_q [$];
   logic [11:0] bar_tab [8];

   vga_gpu #(.V_ACTIVE(V_ACT)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .red     (red),
      .green   (green),
      .blue    (blue),
      .h_sync  (h_sync),
      .v_sync  (v_sync)
   );

   always #5 clk = ~clk;

   // Sample k is taken after the k-th edge following release; the raster holds
   // (0,0) for one extra edge, so sample k shows position max(k-1, 0).
   function automatic logic [13:0] model(input int p);
      int h, line, frame, col;
      logic [11:0] rgb;
      logic hs, vs;
      h     = p % H_TOT;
      line  = (p / H_TOT) % V_TOT;
      frame = (p / FRAME) % 256;
      col   = h;
`ifdef VGA_GPU_SCROLL_EN
      col = (h + frame) % H_ACT;
`endif
      rgb = (h < H_ACT && line < V_ACT) ? bar_tab[col / 25] : 12'h000;
      hs  = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC);
      vs  = (line >= V_ACT + V_FP) && (line < V_ACT + V_FP + V_SYNC);
      return {rgb, hs, vs};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   task automatic run_to(input int target);
      while (k < target) tick();
   endtask

   task automatic test_reset();
      aresetn = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({red, green, blue} !== 12'h000) begin
         n_fail++; $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
      end
      n_checks++;
      if (h_sync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: got %b expected 0", h_sync); end
      n_checks++;
      if (v_sync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b expected 0", v_sync); end
      aresetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      k = 0;
      n_checks++;
      if ({red, green, blue} !== 12'hFFF) begin
         n_fail++; $display("FAIL release_rgb: got %h expected fff", {red, green, blue});
      end
      n_checks++;
      if ({h_sync, v_sync} !== 2'b00) begin
         n_fail++; $display("FAIL release_sync: got %b expected 00", {h_sync, v_sync});
      end
   endtask

   task automatic test_line_timing();
      int rises [$];
      int fall_k;
      logic prev;
      fall_k = -1;
      prev = h_sync;
      while (k < 2 * H_TOT + 260) begin
         tick();
         if (h_sync && !prev) rises.push_back(k);
         if (!h_sync && prev && rises.size() == 1 && fall_k < 0) fall_k = k;
         prev = h_sync;
      end
      n_checks++;
      if (rises.size() != 3) begin
         n_fail++; $display("FAIL hsync_rise_count: got %0d expected 3", rises.size());
      end else begin
         n_checks++;
         if (rises[0] != H_RISE_K) begin
            n_fail++; $display("FAIL hsync_first_rise: got %0d expected %0d", rises[0], H_RISE_K);
         end
         for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (rises[i] - rises[i-1] != H_TOT) begin
               n_fail++; $display("FAIL hsync_period: got %0d expected %0d", rises[i] - rises[i-1], H_TOT);
            end
         end
         n_checks++;
         if (fall_k - rises[0] != H_SYNC) begin
            n_fail++; $display("FAIL hsync_width: got %0d expected %0d", fall_k - rises[0], H_SYNC);
         end
      end
   endtask

   task automatic test_vblank();
      logic [11:0] e;
      run_to(V_ACT * H_TOT);
      for (int i = 0; i < (V_TOT - V_ACT) * H_TOT; i++) begin
         rgb_q.push_back(12'h000);
         tick();
         e = rgb_q.pop_front();
         n_checks++;
         if ({red, green, blue} !== e) begin
            n_fail++; $display("FAIL vblank_rgb k=%0d: got %h expected %h", k, {red, green, blue}, e);
         end
      end
   endtask

   task automatic test_bars();
      logic [13:0] e, got;
      int lead;
      bit in_lead;
      lead = 0;
      in_lead = 1'b1;
      run_to(FRAME);
      for (int i = 0; i < H_TOT; i++) begin
         exp_q.push_back(model(k));
         tick();
         got = {red, green, blue, h_sync, v_sync};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL bars h=%0d: got %h expected %h", i, got, e);
         end
         if (in_lead && got[13:2] == 12'hFFF) lead++;
         else in_lead = 1'b0;
      end
      n_checks++;
      if (lead != LEAD_F1) begin
         n_fail++; $display("FAIL bars_white_width: got %0d expected %0d", lead, LEAD_F1);
      end
   endtask

   task automatic test_frame_timing();
      int rises [$];
      int fall_k;
      logic prev;
      fall_k = -1;
      prev = v_sync;
      while (rises.size() < 4 && k < 6 * FRAME) begin
         tick();
         if (v_sync && !prev) rises.push_back(k);
         if (!v_sync && prev && rises.size() >= 1 && fall_k < 0) fall_k = k;
         prev = v_sync;
      end
      n_checks++;
      if (rises.size() != 4) begin
         n_fail++; $display("FAIL vsync_rise_count: got %0d expected 4", rises.size());
      end else begin
         n_checks++;
         if (rises[0] != FRAME + (V_ACT + V_FP) * H_TOT + 1) begin
            n_fail++; $display("FAIL vsync_phase: got %0d expected %0d", rises[0],
                               FRAME + (V_ACT + V_FP) * H_TOT + 1);
         end
         for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (rises[i] - rises[i-1] != FRAME) begin
               n_fail++; $display("FAIL vsync_period: got %0d expected %0d", rises[i] - rises[i-1], FRAME);
            end
         end
         n_checks++;
         if (fall_k - rises[0] != V_SYNC * H_TOT) begin
            n_fail++; $display("FAIL vsync_width: got %0d expected %0d", fall_k - rises[0], V_SYNC * H_TOT);
         end
      end
   endtask

   task automatic test_mid_reset();
      int target, rise_k, lead;
      bit in_lead;
      logic prev;
      logic [13:0] e, got;
      target = ((k - 1) / FRAME + 1) * FRAME + 5 * H_TOT + 100;
      run_to(target + 1);
      aresetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({red, green, blue, h_sync, v_sync} !== 14'h0) begin
         n_fail++; $display("FAIL midreset_zero: got %h expected 0000", {red, green, blue, h_sync, v_sync});
      end
      aresetn = 1'b0;
      @(negedge clk);
      k = 0;
      n_checks++;
      if ({red, green, blue, h_sync, v_sync} !== {12'hFFF, 2'b00}) begin
         n_fail++; $display("FAIL midreset_restart: got %h expected 3ffc", {red, green, blue, h_sync, v_sync});
      end
      rise_k = -1;
      prev = h_sync;
      while (rise_k < 0 && k < 2 * H_TOT) begin
         tick();
         if (h_sync && !prev) rise_k = k;
         prev = h_sync;
      end
      n_checks++;
      if (rise_k != H_RISE_K) begin
         n_fail++; $display("FAIL midreset_hsync_rise: got %0d expected %0d", rise_k, H_RISE_K);
      end
      lead = 0;
      in_lead = 1'b1;
      run_to(FRAME);
      for (int i = 0; i < 30; i++) begin
         exp_q.push_back(model(k));
         tick();
         got = {red, green, blue, h_sync, v_sync};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL midreset_frame1 h=%0d: got %h expected %h", i, got, e);
         end
         if (in_lead && got[13:2] == 12'hFFF) lead++;
         else in_lead = 1'b0;
      end
      n_checks++;
      if (lead != LEAD_F1) begin
         n_fail++; $display("FAIL midreset_white_width: got %0d expected %0d", lead, LEAD_F1);
      end
   endtask

   initial begin
      bar_tab = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      k = 0;
      test_reset();
      test_line_timing();
      test_vblank();
      test_bars();
      test_frame_timing();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
